// File: rtl/nonogram_pkg.sv
// Shared types for the line-option dispatcher: queue entry layout,
// dispatch state encoding and option-memory address helper.
package nonogram_pkg;

  localparam int unsigned BOARD_SIZE = 4;
  localparam int unsigned NUM_W      = BOARD_SIZE + 1;
  localparam int unsigned MEM_AW     = 8;

  typedef struct packed {
    logic                  row;
    logic [BOARD_SIZE-1:0] line;
    logic [NUM_W-1:0]      num;
    logic [NUM_W-1:0]      cursor;
    logic [MEM_AW-1:0]     base;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RD,
    ST_ISSUE,
    ST_WAIT,
    ST_RD_LAST,
    ST_SWAP,
    ST_DONE
  } disp_state_t;

  // Address of option idx of a line; wraps modulo 2**MEM_AW.
  function automatic logic [MEM_AW-1:0] opt_addr(input logic [MEM_AW-1:0] base,
                                                 input logic [NUM_W-1:0]  idx);
    return base + MEM_AW'(idx);
  endfunction

endpackage

// File: rtl/line_option_dispatcher_queue.sv
// Circular buffer of unresolved line entries feeding the dispatcher.
module line_queue
  import nonogram_pkg::*;
#(
  parameter int unsigned DEPTH = 2 * BOARD_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             slots_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = slots_q[head_q];

  // A push while full is only legal when a pop frees the head slot in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    head_d  = pop_ok ? ptr_inc(head_q) : head_q;
    tail_d  = push_ok ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      slots_q[tail_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/line_option_dispatcher.sv
// Producer side of the line solver's option/put-back protocol: issues one
// candidate option per turn from a circular queue of unresolved lines.
module line_option_dispatcher
  import nonogram_pkg::*;
#(
  parameter int unsigned SIZE      = BOARD_SIZE,
  parameter int unsigned DEPTH     = 2 * SIZE,
  parameter int unsigned ADDR_W    = MEM_AW,
  parameter int unsigned STALL_LIM = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_row,
  input  logic [SIZE-1:0]   load_line,
  input  logic [SIZE:0]     load_num,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [SIZE-1:0]   mem_rdata,
  output logic              mem_we,
  output logic [SIZE-1:0]   mem_wdata,
  output logic [SIZE-1:0]   option,
  output logic [SIZE-1:0]   line_ind,
  output logic              row,
  output logic [SIZE:0]     option_num,
  output logic              valid_op,
  input  logic              resp_valid,
  input  logic              resp_put_back,
  output logic              busy,
  output logic              done,
  output logic              stuck
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned STALL_W = $clog2(STALL_LIM + 1);

  disp_state_t        state_q, state_d;
  entry_t             work_q, work_d;
  entry_t             nxt_c;
  entry_t             load_entry_c;
  entry_t             q_head;
  entry_t             q_push_data;
  logic [SIZE-1:0]    opt_q, opt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [STALL_W-1:0] stall_inc;
  logic               done_q, done_d;
  logic               stuck_q, stuck_d;
  logic               q_push;
  logic               q_pop;
  logic               q_full;
  logic               q_empty;
  logic [CNT_W-1:0]   q_count;
  logic [NUM_W-1:0]   cur_inc;
  logic [NUM_W-1:0]   num_dec;

  line_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign load_entry_c = '{row: load_row, line: load_line, num: load_num,
                          cursor: '0, base: load_base};

  assign cur_inc   = work_q.cursor + NUM_W'(1);
  assign num_dec   = work_q.num - NUM_W'(1);
  assign stall_inc = stall_q + STALL_W'(1);

  assign load_ready = (state_q == ST_IDLE) && !q_full;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = done_q;
  assign stuck      = stuck_q;
  assign option     = opt_q;
  assign line_ind   = work_q.line;
  assign row        = work_q.row;
  assign option_num = work_q.num;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    opt_d       = opt_q;
    stall_d     = stall_q;
    done_d      = done_q;
    stuck_d     = stuck_q;
    nxt_c       = work_q;
    q_push      = 1'b0;
    q_push_data = work_q;
    q_pop       = 1'b0;
    mem_addr    = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    valid_op    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_valid && load_ready && (load_num != '0)) begin
          q_push      = 1'b1;
          q_push_data = load_entry_c;
        end
        if (start) begin
          if (q_empty) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        q_pop    = 1'b1;
        work_d   = q_head;
        mem_addr = opt_addr(q_head.base, q_head.cursor);
        mem_re   = 1'b1;
        state_d  = ST_RD;
      end

      ST_RD: begin
        opt_d   = mem_rdata;
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        valid_op = 1'b1;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (resp_valid) begin
          if (work_q.num == NUM_W'(1)) begin
            stall_d = '0;
            if (q_count == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
          end else if (resp_put_back) begin
            nxt_c.cursor = (cur_inc == work_q.num) ? '0 : cur_inc;
            work_d       = nxt_c;
            q_push       = 1'b1;
            q_push_data  = nxt_c;
            stall_d      = stall_inc;
            if (stall_inc == STALL_W'(STALL_LIM)) begin
              stuck_d = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            // Cursor < num always, so cursor >= num-1 reduces to equality;
            // after a swap the cursor is already inside the shrunk range.
            stall_d   = '0;
            nxt_c.num = num_dec;
            if (work_q.cursor != num_dec) begin
              work_d  = nxt_c;
              state_d = ST_RD_LAST;
            end else begin
              nxt_c.cursor = '0;
              work_d       = nxt_c;
              q_push       = 1'b1;
              q_push_data  = nxt_c;
              state_d      = ST_FETCH;
            end
          end
        end
      end

      ST_RD_LAST: begin
        mem_addr = opt_addr(work_q.base, work_q.num);
        mem_re   = 1'b1;
        state_d  = ST_SWAP;
      end

      ST_SWAP: begin
        mem_we      = 1'b1;
        mem_addr    = opt_addr(work_q.base, work_q.cursor);
        mem_wdata   = mem_rdata;
        q_push      = 1'b1;
        q_push_data = work_q;
        state_d     = ST_FETCH;
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      opt_q   <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      opt_q   <= opt_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      stuck_q <= stuck_d;
    end
  end

endmodule

// File: tb/tb_line_option_dispatcher.sv
// Self-checking bench for line_option_dispatcher with a queue-based reference model.
module tb_line_option_dispatcher;

  localparam int TMO = 64;
  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       load_row = 1'b0;
  logic [3:0] load_line = '0;
  logic [4:0] load_num = '0;
  logic [7:0] load_base = '0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic [3:0] mem_rdata = '0;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic [3:0] option;
  logic [3:0] line_ind;
  logic       row;
  logic [4:0] option_num;
  logic       valid_op;
  logic       resp_valid = 1'b0;
  logic       resp_put_back = 1'b0;
  logic       busy;
  logic       done;
  logic       stuck;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  line_option_dispatcher #(
    .SIZE      (4),
    .DEPTH     (8),
    .ADDR_W    (8),
    .STALL_LIM (LIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_row      (load_row),
    .load_line     (load_line),
    .load_num      (load_num),
    .load_base     (load_base),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .option        (option),
    .line_ind      (line_ind),
    .row           (row),
    .option_num    (option_num),
    .valid_op      (valid_op),
    .resp_valid    (resp_valid),
    .resp_put_back (resp_put_back),
    .busy          (busy),
    .done          (done),
    .stuck         (stuck)
  );

  // Option memory: one-cycle read latency, DUT writes take priority over preload.
  logic [3:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [3:0] pre_data = '0;
  int         wr_cnt = 0;
  logic [7:0] last_waddr = '0;
  logic [3:0] last_wdata = '0;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  typedef struct {
    logic       row;
    logic [3:0] line;
    int         num;
    int         cursor;
    int         base;
  } m_entry_t;

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    load_valid = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_put_back = 1'b0; pre_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] a, input logic [3:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic load_entry(input logic r, input logic [3:0] l, input logic [4:0] n,
                            input logic [7:0] b, output logic acc);
    load_valid = 1'b1; load_row = r; load_line = l; load_num = n; load_base = b;
    acc = load_ready;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_issue(output logic ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < TMO) begin
      if (valid_op === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
  endtask

  task automatic verdict(input logic pb);
    @(negedge clk);
    resp_valid = 1'b1; resp_put_back = pb;
    @(negedge clk);
    resp_valid = 1'b0; resp_put_back = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({load_ready, busy, done, stuck, valid_op, mem_re, mem_we, row} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10000000",
               {load_ready, busy, done, stuck, valid_op, mem_re, mem_we, row});
    end
    n_cmp++;
    if ({option, line_ind, option_num, mem_addr, mem_wdata} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_buses: got %h want 0", {option, line_ind, option_num, mem_addr, mem_wdata});
    end
    do_reset();
  endtask

  task automatic test_single;
    logic acc, ok;
    int   w;
    do_reset();
    poke(8'h10, 4'b1010);
    load_entry(1'b1, 4'd2, 5'd1, 8'h10, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL single_load: got %b want 1", acc); end
    pulse_start();
    wait_issue(ok, w);
    n_cmp++;
    if (!ok || w != 2) begin n_bad++; $display("FAIL single_latency: got %0d (ok=%b) want 2", w, ok); end
    n_cmp++;
    if ({option, line_ind, row, option_num} !== {4'b1010, 4'd2, 1'b1, 5'd1}) begin
      n_bad++;
      $display("FAIL single_issue: got %h/%h/%b/%h want a/2/1/01", option, line_ind, row, option_num);
    end
    @(negedge clk);
    n_cmp++;
    if ({valid_op, option} !== {1'b0, 4'b1010}) begin
      n_bad++;
      $display("FAIL single_pulse_hold: got valid_op=%b option=%h want 0/a", valid_op, option);
    end
    resp_valid = 1'b1; resp_put_back = 1'b0;
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({done, busy, stuck, load_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL single_done: got done/busy/stuck/ready=%b want 1000", {done, busy, stuck, load_ready});
    end
  endtask

  task automatic test_put_back_wrap;
    logic [3:0] eo [6] = '{4'h3, 4'h5, 4'h9, 4'h3, 4'h9, 4'h5};
    logic [4:0] en [6] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd2, 5'd1};
    logic       pb [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int         el [6] = '{2, 2, 2, 2, 4, 4};
    logic acc, ok;
    int   w;
    do_reset();
    poke(8'h20, 4'h3); poke(8'h21, 4'h5); poke(8'h22, 4'h9);
    load_entry(1'b0, 4'd1, 5'd3, 8'h20, acc);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      wait_issue(ok, w);
      n_cmp++;
      if (!ok || w != el[i] || option !== eo[i] || option_num !== en[i] || line_ind !== 4'd1) begin
        n_bad++;
        $display("FAIL wrap_issue%0d: got opt=%h num=%0d line=%0d lat=%0d want opt=%h num=%0d line=1 lat=%0d",
                 i, option, option_num, line_ind, w, eo[i], en[i], el[i]);
      end
      verdict(pb[i]);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({done, stuck, mem[8'h20], mem[8'h22]} !== {1'b1, 1'b0, 4'h5, 4'h9}) begin
      n_bad++;
      $display("FAIL wrap_end: got done=%b stuck=%b m20=%h m22=%h want 1 0 5 9", done, stuck, mem[8'h20], mem[8'h22]);
    end
  endtask

  task automatic test_swap;
    logic acc, ok;
    int   w, w0;
    do_reset();
    poke(8'h30, 4'h1); poke(8'h31, 4'h2); poke(8'h32, 4'h7);
    load_entry(1'b0, 4'd3, 5'd3, 8'h30, acc);
    pulse_start();
    wait_issue(ok, w);
    n_cmp++;
    if (!ok || option !== 4'h1) begin n_bad++; $display("FAIL swap_first: got %h want 1", option); end
    w0 = wr_cnt;
    verdict(1'b0);
    wait_issue(ok, w);
    n_cmp++;
    if (!ok || w != 4 || option !== 4'h7 || option_num !== 5'd2) begin
      n_bad++;
      $display("FAIL swap_next: got opt=%h num=%0d lat=%0d want opt=7 num=2 lat=4", option, option_num, w);
    end
    n_cmp++;
    if (wr_cnt - w0 != 1 || last_waddr !== 8'h30 || last_wdata !== 4'h7 || mem[8'h30] !== 4'h7) begin
      n_bad++;
      $display("FAIL swap_write: got writes=%0d addr=%h data=%h want 1 30 7", wr_cnt - w0, last_waddr, last_wdata);
    end
  endtask

  task automatic test_no_swap_tail;
    logic acc, ok;
    int   w, w0;
    logic [3:0] eo [3] = '{4'h4, 4'h6, 4'h8};
    do_reset();
    poke(8'h40, 4'h4); poke(8'h41, 4'h6); poke(8'h42, 4'h8);
    load_entry(1'b1, 4'd5, 5'd3, 8'h40, acc);
    pulse_start();
    w0 = 0;
    for (int i = 0; i < 3; i++) begin
      wait_issue(ok, w);
      n_cmp++;
      if (!ok || option !== eo[i]) begin n_bad++; $display("FAIL tail_issue%0d: got %h want %h", i, option, eo[i]); end
      w0 = wr_cnt;
      verdict(i < 2);
    end
    wait_issue(ok, w);
    n_cmp++;
    if (!ok || w != 2 || option !== 4'h4 || option_num !== 5'd2 || wr_cnt != w0) begin
      n_bad++;
      $display("FAIL tail_wrap: got opt=%h num=%0d lat=%0d writes=%0d want opt=4 num=2 lat=2 writes=0",
               option, option_num, w, wr_cnt - w0);
    end
  endtask

  task automatic test_stuck;
    logic acc, ok;
    int   w, hits;
    logic [3:0] eo [4] = '{4'h1, 4'h3, 4'h2, 4'h4};
    logic [3:0] el [4] = '{4'd0, 4'd3, 4'd0, 4'd3};
    do_reset();
    poke(8'h50, 4'h1); poke(8'h51, 4'h2); poke(8'h58, 4'h3); poke(8'h59, 4'h4);
    load_entry(1'b1, 4'd0, 5'd2, 8'h50, acc);
    load_entry(1'b0, 4'd3, 5'd2, 8'h58, acc);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_issue(ok, w);
      n_cmp++;
      if (!ok || option !== eo[i] || line_ind !== el[i]) begin
        n_bad++;
        $display("FAIL stuck_issue%0d: got opt=%h line=%0d want opt=%h line=%0d", i, option, line_ind, eo[i], el[i]);
      end
      verdict(1'b1);
    end
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_op === 1'b1) hits++;
    end
    n_cmp++;
    if ({stuck, done, busy} !== 3'b100 || hits != 0) begin
      n_bad++;
      $display("FAIL stuck_flags: got stuck/done/busy=%b issues=%0d want 100 0", {stuck, done, busy}, hits);
    end
  endtask

  task automatic test_full_and_reset;
    logic acc, ok;
    int   w, taken;
    do_reset();
    poke(8'h60, 4'hE);
    load_entry(1'b0, 4'd0, 5'd0, 8'h70, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL zero_num_handshake: got %b want 1", acc); end
    taken = 0;
    for (int i = 0; i < 8; i++) begin
      load_entry(1'(i), 4'(i), 5'd1, 8'h60 + 8'(i), acc);
      if (acc === 1'b1) taken++;
    end
    n_cmp++;
    if (taken != 8) begin n_bad++; $display("FAIL fill_accept: got %0d want 8", taken); end
    load_entry(1'b0, 4'd1, 5'd1, 8'h70, acc);
    n_cmp++;
    if (acc !== 1'b0) begin n_bad++; $display("FAIL full_refuse: got ready=%b want 0", acc); end
    pulse_start();
    wait_issue(ok, w);
    n_cmp++;
    if (!ok || option !== 4'hE) begin n_bad++; $display("FAIL full_first: got %h want e", option); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({load_ready, busy, done, stuck, valid_op, mem_re, mem_we, row} !== 8'b1000_0000 ||
        {option, line_ind, option_num, mem_addr, mem_wdata} !== 25'd0) begin
      n_bad++;
      $display("FAIL midwait_reset: got flags=%b buses=%h want 10000000 0",
               {load_ready, busy, done, stuck, valid_op, mem_re, mem_we, row},
               {option, line_ind, option_num, mem_addr, mem_wdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_valid = 1'b1; resp_put_back = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0; resp_put_back = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, valid_op, load_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL stray_resp: got busy/valid_op/ready=%b want 001", {busy, valid_op, load_ready});
    end
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL empty_start: got done/busy=%b want 10", {done, busy});
    end
  endtask

  task automatic test_random;
    m_entry_t   mq[$];
    m_entry_t   e;
    int         mmem [256];
    int         ld_base [8];
    int         ld_num [8];
    int         k, stall, steps, nn, exp_lat, w, a, v;
    logic       acc, ok, pb, finished, exp_done, exp_stuck;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      mq.delete();
      k = (r == 0) ? 8 : int'($urandom_range(1, 8));
      for (int i = 0; i < k; i++) begin
        e.row    = 1'($urandom_range(0, 1));
        e.line   = 4'($urandom_range(0, 3));
        e.num    = int'($urandom_range(1, 4));
        e.cursor = 0;
        e.base   = (i == 7) ? 'hFE : 'h80 + 16 * i;
        ld_base[i] = e.base;
        ld_num[i]  = e.num;
        for (int j = 0; j < e.num; j++) begin
          a = (e.base + j) % 256;
          v = int'($urandom_range(0, 15));
          mmem[a] = v;
          poke(8'(a), 4'(v));
        end
        load_entry(e.row, e.line, 5'(e.num), 8'(e.base), acc);
        n_cmp++;
        if (acc !== 1'b1) begin n_bad++; $display("FAIL rnd_load r%0d: got %b want 1", r, acc); end
        mq.push_back(e);
      end
      pulse_start();
      stall = 0; steps = 0; exp_lat = 2;
      finished = 1'b0; exp_done = 1'b0; exp_stuck = 1'b0;
      while (!finished && steps < 100) begin
        e = mq.pop_front();
        a = (e.base + e.cursor) % 256;
        wait_issue(ok, w);
        n_cmp++;
        if (!ok || w != exp_lat ||
            {option, line_ind, row, option_num} !== {4'(mmem[a]), e.line, e.row, 5'(e.num)}) begin
          n_bad++;
          $display("FAIL rnd_issue r%0d s%0d: got opt=%h line=%0d row=%b num=%0d lat=%0d want %h %0d %b %0d %0d",
                   r, steps, option, line_ind, row, option_num, w, mmem[a], e.line, e.row, e.num, exp_lat);
        end
        pb = 1'($urandom_range(0, 1));
        verdict(pb);
        exp_lat = 2;
        if (e.num == 1) begin
          stall = 0;
        end else if (pb) begin
          e.cursor = (e.cursor + 1) % e.num;
          mq.push_back(e);
          stall++;
        end else begin
          nn = e.num - 1;
          if (e.cursor == nn) e.cursor = 0;
          else begin
            mmem[(e.base + e.cursor) % 256] = mmem[(e.base + nn) % 256];
            exp_lat = 4;
          end
          e.num = nn;
          mq.push_back(e);
          stall = 0;
        end
        if (mq.size() == 0) begin
          finished = 1'b1; exp_done = 1'b1;
        end else if (stall == LIM) begin
          finished = 1'b1; exp_stuck = 1'b1;
        end
        steps++;
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({done, stuck, busy} !== {exp_done, exp_stuck, 1'b0}) begin
        n_bad++;
        $display("FAIL rnd_end r%0d: got done/stuck/busy=%b want %b%b0", r, {done, stuck, busy}, exp_done, exp_stuck);
      end
      for (int i = 0; i < k; i++) begin
        for (int j = 0; j < ld_num[i]; j++) begin
          a = (ld_base[i] + j) % 256;
          n_cmp++;
          if (mem[a] !== 4'(mmem[a])) begin
            n_bad++;
            $display("FAIL rnd_mem r%0d @%h: got %h want %h", r, a, mem[a], mmem[a]);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_put_back_wrap();
    test_swap();
    test_no_swap_tail();
    test_stuck();
    test_full_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
